// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader. It receives a length-prefixed, checksummed
// program over a valid/ready byte stream and assembles big-endian 32-bit
// words. Each word goes to the instruction memory write port. The CPU is
// held in reset until a load completes with a good checksum.
//
// Stream format:
//   N[15:8], N[7:0], then 4*N data bytes (each word MSB first), then one
//   checksum byte equal to the XOR of all data bytes.
//
// Parameters:
//   BASE_ADDR  byte address of word 0 (word-aligned)
//   MAX_WORDS  largest accepted program length in words
//
// Ports:
//   i_clk            single clock, rising edge
//   i_reset          synchronous, active-high reset
//   i_start          one-cycle pulse that begins a load (IDLE/DONE/ERROR only)
//   i_rx_data        incoming byte
//   i_rx_valid       i_rx_data is valid
//   o_rx_ready       loader accepts a byte this cycle
//   o_imem_we        instruction memory write strobe (one cycle per word)
//   o_imem_addr      byte address of the write, word-aligned
//   o_imem_wdata     word being written
//   o_cpu_hold       hold the CPU in reset while high
//   o_done           load completed with a good checksum
//   o_error          load rejected (bad length or bad checksum)
//   o_words_loaded   number of words written in the current load
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_words_loaded
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  // FSM and datapath registers
  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_index;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_csum;
  logic [31:0] r_word;

  // Registered outputs
  logic        r_rx_ready;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words_loaded;

  // Combinational helpers
  logic        w_accept;
  logic [15:0] w_len_full;
  logic        w_len_bad;
  logic [31:0] w_word_next;
  logic [15:0] w_index_inc;
  logic        w_last_word;
  logic [31:0] w_addr;

  // A byte is consumed only when the loader itself advertised ready; the
  // registered ready is the single source of truth for acceptance.
  assign w_accept    = i_rx_valid & r_rx_ready;

  // The high count byte was parked in r_len[7:0] during LEN_HI, so the
  // full count is available in the same cycle the low byte arrives.
  assign w_len_full  = {r_len[7:0], i_rx_data};
  assign w_len_bad   = (w_len_full == 16'd0) ||
                       ({16'd0, w_len_full} > MAX_WORDS_W);

  assign w_word_next = {r_word[23:0], i_rx_data};
  assign w_index_inc = r_index + 16'd1;
  assign w_last_word = (w_index_inc == r_len);

  // Index is bounded by MAX_WORDS-1, so the 32-bit sum never exceeds
  // BASE_ADDR + 4*(MAX_WORDS-1).
  assign w_addr      = BASE_ADDR + {14'd0, r_index, 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_len          <= 16'd0;
      r_index        <= 16'd0;
      r_byte_cnt     <= 2'd0;
      r_csum         <= 8'd0;
      r_word         <= 32'd0;
      r_rx_ready     <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= BASE_ADDR;
      r_imem_wdata   <= 32'd0;
      r_cpu_hold     <= 1'b1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= 16'd0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      r_imem_we <= 1'b0;

      case (r_state)
        // Idle, and the two terminal states, only react to start; a start
        // here begins a fresh load and wipes the previous result.
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state        <= S_LEN_HI;
            r_index        <= 16'd0;
            r_byte_cnt     <= 2'd0;
            r_csum         <= 8'd0;
            r_words_loaded <= 16'd0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_cpu_hold     <= 1'b1;
            r_rx_ready     <= 1'b1;
          end
        end

        S_LEN_HI: begin
          if (w_accept) begin
            r_len   <= {8'd0, i_rx_data};
            r_state <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len_full;
            if (w_len_bad) begin
              r_state    <= S_ERROR;
              r_rx_ready <= 1'b0;
              r_error    <= 1'b1;
              r_cpu_hold <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_word     <= w_word_next;
            r_csum     <= r_csum ^ i_rx_data;
            // Two-bit counter wraps back to zero after the 4th byte.
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Present the completed word during the WRITE cycle; ready
              // drops so no byte can arrive while the write is in flight.
              r_state      <= S_WRITE;
              r_rx_ready   <= 1'b0;
              r_imem_we    <= 1'b1;
              r_imem_addr  <= w_addr;
              r_imem_wdata <= w_word_next;
            end
          end
        end

        S_WRITE: begin
          r_index        <= w_index_inc;
          r_words_loaded <= r_words_loaded + 16'd1;
          r_rx_ready     <= 1'b1;
          r_state        <= w_last_word ? S_CSUM : S_DATA;
        end

        S_CSUM: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state    <= S_ERROR;
              r_error    <= 1'b1;
              r_cpu_hold <= 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready     = r_rx_ready;
  assign o_imem_we      = r_imem_we;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = r_imem_wdata;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Table-driven vectors cover the
// documented load scenarios, hand-written sequences cover reset mid-load
// and start handling, and randomized loads are checked against a stream
// parser model that works directly from the byte stream.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 512;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_words_loaded;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_rx_ready     (o_rx_ready),
    .o_imem_we      (o_imem_we),
    .o_imem_addr    (o_imem_addr),
    .o_imem_wdata   (o_imem_wdata),
    .o_cpu_hold     (o_cpu_hold),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_words_loaded (o_words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  stream[$];
  logic [31:0] prog[$];
  logic [63:0] wq[$];
  logic [63:0] exp_wq[$];
  bit          m_done;
  bit          m_err;
  int          m_words;
  int          m_consumed;
  int          acc_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", nm, act);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (i_rx_valid && o_rx_ready) acc_cnt++;
    if (o_imem_we) begin
      wq.push_back({o_imem_addr, o_imem_wdata});
      chk("rx_ready_low_during_we", 64'(o_rx_ready), 64'd0);
    end
  end

  // Reference model: parse the stream as the protocol defines it.
  task automatic model();
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_wq.delete();
    n = int'({stream[0], stream[1]});
    if (n == 0 || n > MAXW) begin
      m_err = 1; m_done = 0; m_words = 0; m_consumed = 2;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
      exp_wq.push_back({BASE + 32'(4*i), w});
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    m_words    = n;
    m_consumed = 2 + 4*n + 1;
    m_done     = (stream[2+4*n] == x);
    m_err      = !m_done;
  endtask

  // Build a stream from prog[] with the given count; delta corrupts the checksum.
  task automatic build(input logic [15:0] len, input logic [7:0] delta);
    logic [7:0] x;
    stream.delete();
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    if (len != 0 && int'(len) <= MAXW) begin
      x = 8'd0;
      for (int i = 0; i < int'(len); i++) begin
        for (int b = 3; b >= 0; b--) begin
          stream.push_back(prog[i][8*b +: 8]);
          x = x ^ prog[i][8*b +: 8];
        end
      end
      stream.push_back(x ^ delta);
    end
  endtask

  task automatic set_spec_prog();
    prog.delete();
    prog.push_back(32'h2008_0005);
    prog.push_back(32'h0109_4020);
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g, n;
    bit got;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin @(posedge clk); #1; end
    i_rx_data = b; i_rx_valid = 1'b1; got = 0; n = 0;
    while (!got && n < 64) begin
      @(negedge clk);
      if (o_rx_ready) got = 1; else n++;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL rx_ready_timeout: got ready=0 for 64 cycles expected ready=1");
    end
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic feed(input int maxgap, input int glitch_at);
    for (int i = 0; i < m_consumed; i++) begin
      if (i == glitch_at) pulse_start();
      send_byte(stream[i], maxgap);
    end
  endtask

  task automatic finish_check(input string tag);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk({tag, ".done"},     64'(o_done),         64'(m_done));
    chk({tag, ".error"},    64'(o_error),        64'(m_err));
    chk({tag, ".cpu_hold"}, 64'(o_cpu_hold),     64'(!m_done));
    chk({tag, ".words"},    64'(o_words_loaded), 64'(m_words));
    chk({tag, ".rx_ready"}, 64'(o_rx_ready),     64'd0);
    chk({tag, ".bytes"},    64'(acc_cnt),        64'(m_consumed));
    chk({tag, ".nwrites"},  64'(wq.size()),      64'(exp_wq.size()));
    for (int i = 0; i < wq.size() && i < exp_wq.size(); i++)
      chk($sformatf("%s.write%0d", tag, i), wq[i], exp_wq[i]);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input string tag, input int maxgap, input int glitch_at);
    model();
    wq.delete();
    acc_cnt = 0;
    pulse_start();
    feed(maxgap, glitch_at);
    finish_check(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rx_ready"}, 64'(o_rx_ready),     64'd0);
    chk({tag, ".we"},       64'(o_imem_we),      64'd0);
    chk({tag, ".addr"},     64'(o_imem_addr),    64'(BASE));
    chk({tag, ".wdata"},    64'(o_imem_wdata),   64'd0);
    chk({tag, ".cpu_hold"}, 64'(o_cpu_hold),     64'd1);
    chk({tag, ".done"},     64'(o_done),         64'd0);
    chk({tag, ".error"},    64'(o_error),        64'd0);
    chk({tag, ".words"},    64'(o_words_loaded), 64'd0);
  endtask

  typedef struct {
    logic [15:0] len;
    logic [7:0]  delta;
    int          maxgap;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{16'd2,   8'h00, 0, 1'b1, 1'b0, 2, 32'h2008_0005}; // normal
    vt[1] = '{16'd2,   8'h01, 0, 1'b0, 1'b1, 2, 32'h2008_0005}; // checksum 0x44
    vt[2] = '{16'd0,   8'h00, 0, 1'b0, 1'b1, 0, 32'h0};         // zero length
    vt[3] = '{16'd513, 8'h00, 0, 1'b0, 1'b1, 0, 32'h0};         // too long
    vt[4] = '{16'd2,   8'h00, 5, 1'b1, 1'b0, 2, 32'h2008_0005}; // rx_valid gaps

    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      set_spec_prog();
      build(vt[v].len, vt[v].delta);
      run_load($sformatf("vec%0d", v), vt[v].maxgap, -1);
      @(negedge clk);
      chk($sformatf("vec%0d.tbl_done", v),  64'(o_done),         64'(vt[v].exp_done));
      chk($sformatf("vec%0d.tbl_error", v), 64'(o_error),        64'(vt[v].exp_err));
      chk($sformatf("vec%0d.tbl_words", v), 64'(o_words_loaded), 64'(vt[v].exp_words));
      chk($sformatf("vec%0d.tbl_nwr", v),   64'(wq.size()),      64'(vt[v].exp_words));
      if (wq.size() > 0)
        chk($sformatf("vec%0d.tbl_w0", v), 64'(wq[0][31:0]), 64'(vt[v].exp_w0));
      @(posedge clk); #1;
    end

    // Start in DONE restarts: previous load (vec4) ended in DONE.
    set_spec_prog();
    build(16'd2, 8'h00);
    model();
    wq.delete();
    acc_cnt = 0;
    pulse_start();
    @(negedge clk);
    chk("restart.done",     64'(o_done),         64'd0);
    chk("restart.cpu_hold", 64'(o_cpu_hold),     64'd1);
    chk("restart.words",    64'(o_words_loaded), 64'd0);
    chk("restart.rx_ready", 64'(o_rx_ready),     64'd1);
    @(posedge clk); #1;
    feed(0, -1);
    finish_check("restart");

    // Reset after the 6th byte (the write of word 0 is in flight).
    set_spec_prog();
    build(16'd2, 8'h00);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    wq.delete();
    @(negedge clk);
    check_reset_vals("midreset");
    repeat (10) @(posedge clk);
    #1;
    chk("midreset.no_we", 64'(wq.size()), 64'd0);
    run_load("after_reset", 0, -1);

    // start pulsed in the middle of DATA is ignored.
    set_spec_prog();
    build(16'd2, 8'h00);
    run_load("start_in_data", 0, 4);

    // Largest legal program: last address is BASE + 4*(MAXW-1).
    prog.delete();
    for (int i = 0; i < MAXW; i++) prog.push_back($urandom);
    build(16'(MAXW), 8'h00);
    run_load("maxlen", 0, -1);
    chk("maxlen.last_addr", 64'(o_imem_addr), 64'(BASE + 32'(4*(MAXW-1))));

    // Randomized loads
    for (int r = 0; r < 25; r++) begin
      int kind;
      logic [15:0] len;
      logic [7:0]  delta;
      kind = int'($urandom_range(9, 0));
      if (kind == 0)      len = 16'd0;
      else if (kind == 1) len = 16'(MAXW + 1 + int'($urandom_range(1000, 0)));
      else                len = 16'($urandom_range(12, 1));
      prog.delete();
      for (int i = 0; i < 12; i++) prog.push_back($urandom);
      delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      build(len, delta);
      run_load($sformatf("rand%0d", r), int'($urandom_range(3, 0)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion by 900000 expected earlier finish");
    $fatal(1);
  end

endmodule
